bus_xfer_sequencer: RTL and testbench
=====================================

Name: bus_xfer_sequencer

Overview:
- Control-step sequencer for the shared-bus datapath (register file, Y, ALU, Z).
- Accepts one register-transfer/ALU command per valid/ready handshake.
- Drives the one-hot register out/in enables, Y/Z strobes and ALU opcode through steps T0..T2.
- Guarantees at most one bus driver per cycle. Sits between the instruction-level control and the datapath.

Parameters:
- NUM_REGS, 16: number of general registers; width of the reg_out/reg_in vectors.
- SEL_W, 4: register select width; must satisfy 2**SEL_W >= NUM_REGS.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 000 MOV, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 NOT, 110/111 illegal.
- cmd_src_a  in  SEL_W  first source register.
- cmd_src_b  in  SEL_W  second source register.
- cmd_dst  in  SEL_W  destination register.
- reg_out  out  NUM_REGS  one-hot register-to-bus enables (RnOut).
- reg_in  out  NUM_REGS  one-hot bus-to-register load enables (RnIn).
- y_in  out  1  load Y from bus.
- z_in  out  1  load Z from ALU.
- z_out  out  1  drive Z onto bus.
- alu_op  out  3  ALU function (cmd_op value); 000 when no ALU step.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse: command finished.
- err  out  1  one-cycle pulse with done: illegal opcode.
- cmd_count  out  16  completed-command counter (see Optional Feature).

Behaviour:
- Reset: state IDLE. Asynchronous assertion forces every output to 0 immediately, except cmd_ready=0 while clear is high. After clear deasserts, cmd_ready=1.
- All outputs are registered or decoded from registered state only. No combinational path from cmd_* to any output.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - Accept on a rising edge with cmd_valid & cmd_ready: latch op/src_a/src_b/dst, move to T0.
  - cmd_* is ignored in all other states.
- States: IDLE, T0, T1, T2, FIN.
- MOV:
  - T0: reg_out[src_a]=1, reg_in[dst]=1.
  - Then FIN.
- ADD/SUB/AND/OR:
  - T0: reg_out[src_a]=1, y_in=1.
  - T1: reg_out[src_b]=1, alu_op=op, z_in=1.
  - T2: z_out=1, reg_in[dst]=1.
  - Then FIN.
- NOT:
  - T0: reg_out[src_a]=1, alu_op=101, z_in=1.
  - T1: z_out=1, reg_in[dst]=1.
  - Then FIN.
- Illegal op (110/111):
  - T0: no datapath signals; err flagged.
  - Then FIN.
- FIN: done=1 (err=1 if illegal), busy=0, no datapath signals, then IDLE. busy=1 in T0..T2.
- Step latency from accept edge to done: MOV 2 cycles, NOT 3, binary ALU ops 4, illegal 2. The next accept is possible one cycle after done.
- Bus exclusivity invariant: in any cycle, popcount(reg_out)+z_out <= 1. reg_in is at most one-hot.
- src==dst is legal. For MOV, reg_out and reg_in assert the same index in T0.
- Select values >= NUM_REGS: treated as illegal. Command runs as the illegal op (err pulse), with no enables.
- clear mid-command: the command is abandoned, no done pulse, state returns to IDLE.

Optional Feature:
- Macro SEQ_CMD_COUNT_EN.
- Defined: cmd_count increments by 1 in each FIN cycle, including illegal commands. It wraps 0xFFFF->0x0000 and is cleared by clear.
- Undefined: no counter logic; cmd_count is tied to 0.

Test Plan:
- Reset: assert clear mid-T1 of ADD R1,R2->R3 -> all enables 0 immediately, no done pulse; after release, cmd_ready=1 and state IDLE.
- MOV src_a=5, dst=2 -> next cycle reg_out=0x0020 and reg_in=0x0004 for one cycle; done the following cycle; no y_in/z_in/z_out.
- SUB src_a=1, src_b=4, dst=7:
  - T0 reg_out=0x0002, y_in.
  - T1 reg_out=0x0010, alu_op=010, z_in.
  - T2 z_out, reg_in=0x0080.
  - done 4 cycles after accept.
- Back-to-back NOT R3->R3 then AND R0,R15->R8 with cmd_valid held -> second command accepted the cycle after first done; bus-exclusivity assertion never fires.
- cmd_op=111 (also NUM_REGS=16, src_a=15 legal check) -> err and done pulse together 2 cycles after accept; all datapath enables 0.
- With SEQ_CMD_COUNT_EN: run 3 commands -> cmd_count=3; preload near 0xFFFF via 65536 commands -> wraps to 0. Without the macro, cmd_count stays 0.

Source files
------------

// File: rtl/bus_xfer_sequencer.sv
// rtl/bus_xfer_sequencer.sv - T0..T2 control-step sequencer for the shared-bus datapath
// Optional SEQ_CMD_COUNT_EN: completed-command counter on cmd_count (tied to 0 otherwise).
module bus_xfer_sequencer #(
  parameter int NUM_REGS = 16,
  parameter int SEL_W    = 4
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [2:0]          cmd_op,
  input  logic [SEL_W-1:0]    cmd_src_a,
  input  logic [SEL_W-1:0]    cmd_src_b,
  input  logic [SEL_W-1:0]    cmd_dst,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_out,
  output logic [2:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         cmd_count
);

  typedef enum logic [2:0] {S_IDLE, S_T0, S_T1, S_T2, S_FIN} state_e;

  localparam logic [2:0]          OP_MOV    = 3'b000;
  localparam logic [2:0]          OP_NOT    = 3'b101;
  localparam logic [NUM_REGS-1:0] ONE_HOT0  = NUM_REGS'(1);
  localparam logic [SEL_W:0]      SEL_LIMIT = (SEL_W+1)'(NUM_REGS);

  state_e              state_q;
  logic [2:0]          op_q;
  logic [SEL_W-1:0]    src_b_q;
  logic [SEL_W-1:0]    dst_q;
  logic                ill_q;
  logic [NUM_REGS-1:0] reg_out_q;
  logic [NUM_REGS-1:0] reg_in_q;
  logic                y_in_q;
  logic                z_in_q;
  logic                z_out_q;
  logic [2:0]          alu_op_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic                cmd_bad;

  function automatic logic sel_bad(input logic [SEL_W-1:0] s);
    return {1'b0, s} >= SEL_LIMIT;
  endfunction

  // src_b only matters for the two-operand ALU ops
  function automatic logic cmd_illegal(input logic [2:0] op, input logic [SEL_W-1:0] a,
                                       input logic [SEL_W-1:0] b, input logic [SEL_W-1:0] d);
    logic bad;
    bad = (op[2:1] == 2'b11) | sel_bad(a) | sel_bad(d);
    if (op != OP_MOV && op != OP_NOT) bad = bad | sel_bad(b);
    return bad;
  endfunction

  function automatic logic [NUM_REGS-1:0] onehot(input logic [SEL_W-1:0] s);
    return ONE_HOT0 << s;
  endfunction

  assign cmd_bad = cmd_illegal(cmd_op, cmd_src_a, cmd_src_b, cmd_dst);

  // Outputs are registered for the state being entered, so each step's enables
  // appear exactly in that step's cycle.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      src_b_q   <= '0;
      dst_q     <= '0;
      ill_q     <= 1'b0;
      reg_out_q <= '0;
      reg_in_q  <= '0;
      y_in_q    <= 1'b0;
      z_in_q    <= 1'b0;
      z_out_q   <= 1'b0;
      alu_op_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      reg_out_q <= '0;
      reg_in_q  <= '0;
      y_in_q    <= 1'b0;
      z_in_q    <= 1'b0;
      z_out_q   <= 1'b0;
      alu_op_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            state_q <= S_T0;
            op_q    <= cmd_op;
            src_b_q <= cmd_src_b;
            dst_q   <= cmd_dst;
            ill_q   <= cmd_bad;
            busy_q  <= 1'b1;
            if (!cmd_bad) begin
              reg_out_q <= onehot(cmd_src_a);
              if (cmd_op == OP_MOV) begin
                reg_in_q <= onehot(cmd_dst);
              end else if (cmd_op == OP_NOT) begin
                alu_op_q <= OP_NOT;
                z_in_q   <= 1'b1;
              end else begin
                y_in_q <= 1'b1;
              end
            end
          end
        end
        S_T0: begin
          if (ill_q || op_q == OP_MOV) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
            err_q   <= ill_q;
          end else if (op_q == OP_NOT) begin
            state_q  <= S_T1;
            busy_q   <= 1'b1;
            z_out_q  <= 1'b1;
            reg_in_q <= onehot(dst_q);
          end else begin
            state_q   <= S_T1;
            busy_q    <= 1'b1;
            reg_out_q <= onehot(src_b_q);
            alu_op_q  <= op_q;
            z_in_q    <= 1'b1;
          end
        end
        S_T1: begin
          if (op_q == OP_NOT) begin
            state_q <= S_FIN;
            done_q  <= 1'b1;
          end else begin
            state_q  <= S_T2;
            busy_q   <= 1'b1;
            z_out_q  <= 1'b1;
            reg_in_q <= onehot(dst_q);
          end
        end
        S_T2: begin
          state_q <= S_FIN;
          done_q  <= 1'b1;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (state_q == S_IDLE) & ~clear;
  assign reg_out   = reg_out_q;
  assign reg_in    = reg_in_q;
  assign y_in      = y_in_q;
  assign z_in      = z_in_q;
  assign z_out     = z_out_q;
  assign alu_op    = alu_op_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

`ifdef SEQ_CMD_COUNT_EN
  logic [15:0] count_q;
  logic [15:0] count_d;

  assign count_d = (state_q == S_FIN) ? count_q + 16'd1 : count_q;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) count_q <= '0;
    else       count_q <= count_d;
  end

  assign cmd_count = count_q;
`else
  assign cmd_count = '0;
`endif

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb/tb_bus_xfer_sequencer.sv - self-checking bench for bus_xfer_sequencer
module tb_bus_xfer_sequencer;
  localparam int NR = 16;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [SW-1:0] cmd_src_a = '0;
  logic [SW-1:0] cmd_src_b = '0;
  logic [SW-1:0] cmd_dst = '0;
  logic [NR-1:0] reg_out;
  logic [NR-1:0] reg_in;
  logic          y_in, z_in, z_out, busy, done, err;
  logic [2:0]    alu_op;
  logic [15:0]   cmd_count;

  bus_xfer_sequencer #(.NUM_REGS(NR), .SEL_W(SW)) dut (
    .clock(clock), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
    .reg_out(reg_out), .reg_in(reg_in), .y_in(y_in), .z_in(z_in), .z_out(z_out),
    .alu_op(alu_op), .busy(busy), .done(done), .err(err), .cmd_count(cmd_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          ready;
    logic          busy;
    logic          done;
    logic          err;
    logic          y;
    logic          zi;
    logic          zo;
    logic [2:0]    alu;
    logic [NR-1:0] ro;
    logic [NR-1:0] ri;
  } snap_t;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] d;
    int         lat;
    bit         err;
    bit         keep;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_count = '0;
  snap_t       exp_q[$];

  function automatic logic [NR-1:0] oh(input logic [3:0] s);
    logic [NR-1:0] one;
    one = 1;
    return one << s;
  endfunction

  function automatic int spec_latency(input logic [2:0] op);
    if (op >= 3'd6) return 2;
    if (op == 3'd0) return 2;
    if (op == 3'd5) return 3;
    return 4;
  endfunction

  // Expected per-cycle output snapshots following an accept edge.
  task automatic model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] d);
    snap_t s;
    bit    ill;
    exp_q.delete();
    ill = (op >= 3'd6) || (int'(a) >= NR) || (int'(d) >= NR) ||
          (op != 3'd0 && op != 3'd5 && int'(b) >= NR);
    s = '0; s.busy = 1'b1;
    if (ill) begin
      exp_q.push_back(s);
    end else if (op == 3'd0) begin
      s.ro = oh(a); s.ri = oh(d);
      exp_q.push_back(s);
    end else if (op == 3'd5) begin
      s.ro = oh(a); s.alu = 3'd5; s.zi = 1'b1;
      exp_q.push_back(s);
      s = '0; s.busy = 1'b1; s.zo = 1'b1; s.ri = oh(d);
      exp_q.push_back(s);
    end else begin
      s.ro = oh(a); s.y = 1'b1;
      exp_q.push_back(s);
      s = '0; s.busy = 1'b1; s.ro = oh(b); s.alu = op; s.zi = 1'b1;
      exp_q.push_back(s);
      s = '0; s.busy = 1'b1; s.zo = 1'b1; s.ri = oh(d);
      exp_q.push_back(s);
    end
    s = '0; s.done = 1'b1; s.err = ill;
    exp_q.push_back(s);
  endtask

  task automatic check_snap(input string name, input snap_t e);
    snap_t a;
    a = {cmd_ready, busy, done, err, y_in, z_in, z_out, alu_op, reg_out, reg_in};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
    checks++;
    if (($countones(reg_out) + int'(z_out)) > 1 || !$onehot0(reg_in)) begin
      errors++;
      $display("FAIL %s bus_exclusive: reg_out=%h z_out=%b reg_in=%h required <=1 driver", name,
               reg_out, z_out, reg_in);
    end
  endtask

  task automatic check_count(input string name);
    logic [15:0] want;
`ifdef SEQ_CMD_COUNT_EN
    want = exp_count;
`else
    want = 16'h0;
`endif
    checks++;
    if (cmd_count !== want) begin
      errors++;
      $display("FAIL %s cmd_count: got %h expected %h", name, cmd_count, want);
    end
  endtask

  task automatic run_cmd(input vec_t v, input string name, output int waited);
    int done_at;
    done_at = -1;
    for (waited = 1; waited <= 20; waited++) begin
      @(negedge clock);
      if (cmd_ready === 1'b1) break;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout: cmd_ready=%b expected 1", name, cmd_ready);
      return;
    end
    check_count(name);
    model(v.op, v.a, v.b, v.d);
    cmd_op = v.op; cmd_src_a = v.a; cmd_src_b = v.b; cmd_dst = v.d;
    cmd_valid = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clock);
      check_snap($sformatf("%s step%0d", name, i), exp_q[i]);
      if (done === 1'b1 && done_at < 0) done_at = i;
      cmd_op = 3'($urandom); cmd_src_a = 4'($urandom);
      cmd_src_b = 4'($urandom); cmd_dst = 4'($urandom);
      if (i == exp_q.size() - 1 && !v.keep) cmd_valid = 1'b0;
    end
    checks++;
    if (done_at + 1 != v.lat || (done_at >= 0 && exp_q[done_at].err != v.err)) begin
      errors++;
      $display("FAIL %s latency: done after %0d cycles expected %0d (err expected %0b)", name,
               done_at + 1, v.lat, v.err);
    end
    exp_count = exp_count + 16'd1;
  endtask

  vec_t  tbl[9];
  snap_t idle_s;
  snap_t zero_s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w;
    int prev_keep;
    tbl[0] = '{3'b000, 4'd5,  4'd0,  4'd2, 2, 1'b0, 1'b0};
    tbl[1] = '{3'b010, 4'd1,  4'd4,  4'd7, 4, 1'b0, 1'b0};
    tbl[2] = '{3'b101, 4'd3,  4'd0,  4'd3, 3, 1'b0, 1'b1};
    tbl[3] = '{3'b011, 4'd0,  4'd15, 4'd8, 4, 1'b0, 1'b0};
    tbl[4] = '{3'b111, 4'd15, 4'd0,  4'd0, 2, 1'b1, 1'b0};
    tbl[5] = '{3'b110, 4'd2,  4'd3,  4'd4, 2, 1'b1, 1'b0};
    tbl[6] = '{3'b001, 4'd6,  4'd9,  4'd6, 4, 1'b0, 1'b1};
    tbl[7] = '{3'b100, 4'd14, 4'd14, 4'd1, 4, 1'b0, 1'b0};
    tbl[8] = '{3'b000, 4'd9,  4'd0,  4'd9, 2, 1'b0, 1'b0};
    zero_s = '0;
    idle_s = '0; idle_s.ready = 1'b1;

    #2 clear = 1'b1;
    #1 check_snap("reset_assert", zero_s);
    check_count("reset_assert");
    @(negedge clock);
    @(negedge clock);
    check_snap("reset_hold", zero_s);
    clear = 1'b0;
    #1 check_snap("reset_release", idle_s);

    prev_keep = 0;
    foreach (tbl[i]) begin
      run_cmd(tbl[i], $sformatf("vec%0d", i), w);
      if (prev_keep != 0) begin
        checks++;
        if (w != 1) begin
          errors++;
          $display("FAIL vec%0d back_to_back: accepted %0d cycles after done expected 1", i, w);
        end
      end
      prev_keep = int'(tbl[i].keep);
    end

    // Abandon ADD R1,R2->R3 in its T1 step.
    @(negedge clock);
    cmd_op = 3'b001; cmd_src_a = 4'd1; cmd_src_b = 4'd2; cmd_dst = 4'd3; cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(posedge clock);
    #2 clear = 1'b1;
    #1 check_snap("clear_mid_t1", zero_s);
    exp_count = '0;
    @(negedge clock);
    check_snap("clear_hold", zero_s);
    clear = 1'b0;
    #1 check_snap("clear_release", idle_s);
    check_count("clear_release");
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check_snap($sformatf("post_clear%0d", i), idle_s);
    end

    for (int i = 0; i < 40; i++) begin
      vec_t v;
      v.op = 3'($urandom_range(0, 7));
      v.a = 4'($urandom_range(0, 15));
      v.b = 4'($urandom_range(0, 15));
      v.d = 4'($urandom_range(0, 15));
      v.lat = spec_latency(v.op);
      v.err = (v.op >= 3'd6);
      v.keep = (i != 39) && ($urandom_range(0, 1) == 1);
      run_cmd(v, $sformatf("rnd%0d", i), w);
    end
    @(negedge clock);
    check_snap("final_idle", idle_s);
    check_count("final_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
